// File: rtl/perif_uart_fifo_if.sv
// Peripheral-bus connection for perif_uart_fifo: word-addressed request
// side driven by the bus master, registered ack/read data returned by the slave.
interface perif_uart_fifo_if;
    logic [9:2]  i_addr;
    logic [3:0]  i_be;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic        i_rd_en;
    logic [31:0] o_rd_data;
    logic        o_busy;
    logic        o_ack;

    modport master (
        output i_addr, i_be, i_wr_en, i_wr_data, i_rd_en,
        input  o_rd_data, o_busy, o_ack
    );

    modport slave (
        input  i_addr, i_be, i_wr_en, i_wr_data, i_rd_en,
        output o_rd_data, o_busy, o_ack
    );
endinterface

// File: rtl/perif_uart_fifo.sv
// UART peripheral with independent TX/RX FIFOs, 5-8 data bits, optional
// even/odd parity, 1 or 2 stop bits, sticky error flags and a maskable
// level interrupt. Memory-mapped slave on the word-addressed peripheral bus.
module perif_uart_fifo #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    perif_uart_fifo_if.slave bus,
    output logic             o_irq,
    input  logic             i_uart_rx,
    output logic             o_uart_tx
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_FULL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_ONE  = (TX_AW+1)'(1);
    localparam logic [RX_AW:0]   RX_ONE  = (RX_AW+1)'(1);
    localparam logic [TX_AW-1:0] TX_PINC = TX_AW'(1);
    localparam logic [RX_AW-1:0] RX_PINC = RX_AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
    function automatic logic par_calc(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // ---------------- registers ----------------
    logic [22:0]       r_cfg;
    logic [2:0]        r_irq_en;
    logic              r_overrun, r_par_err, r_frm_err;
    logic              r_ack;
    logic [31:0]       r_rd_data;

    logic [7:0]        r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  r_tx_wp, r_tx_rp;
    logic [TX_AW:0]    r_tx_cnt;
    uart_state_t       r_tx_state;
    logic [15:0]       r_tx_tmr;
    logic [2:0]        r_tx_bit;
    logic [7:0]        r_tx_shift;
    logic              r_tx_par;
    logic              r_tx_line;

    logic [7:0]        r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  r_rx_wp, r_rx_rp;
    logic [RX_AW:0]    r_rx_cnt;
    logic              r_rx_s1, r_rx_s2, r_rx_s3;
    uart_state_t       r_rx_state;
    logic [15:0]       r_rx_tmr;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic              r_rx_par;

    // ---------------- configuration decode ----------------
    logic [15:0] w_div, w_half;
    logic        w_tx_en, w_rx_en, w_par_en, w_par_odd, w_two_stop;
    logic [2:0]  w_last;
    logic [7:0]  w_mask;

    assign w_div      = (r_cfg[15:0] < 16'd2) ? 16'd2 : r_cfg[15:0];
    assign w_half     = {1'b0, w_div[15:1]};
    assign w_tx_en    = r_cfg[16];
    assign w_rx_en    = r_cfg[17];
    assign w_par_en   = r_cfg[19] ^ r_cfg[18];
    assign w_par_odd  = r_cfg[19];
    assign w_two_stop = r_cfg[20];
    assign w_last     = {1'b0, r_cfg[22:21]} + 3'd4;
    assign w_mask     = 8'hFF >> (3'd7 - w_last);

    // ---------------- bus decode ----------------
    logic w_wr_tx, w_rd_rx, w_wr_cfg, w_wr_stat, w_wr_irq;
    assign w_wr_tx   = bus.i_wr_en & (bus.i_addr == 8'h00) & bus.i_be[0];
    assign w_rd_rx   = bus.i_rd_en & (bus.i_addr == 8'h01);
    assign w_wr_cfg  = bus.i_wr_en & (bus.i_addr == 8'h02);
    assign w_wr_stat = bus.i_wr_en & (bus.i_addr == 8'h03) & bus.i_be[0];
    assign w_wr_irq  = bus.i_wr_en & (bus.i_addr == 8'h04) & bus.i_be[0];

    logic w_unused;
    assign w_unused = ^{bus.i_wr_data[31:23], bus.i_be[3]};

    // ---------------- FIFO status ----------------
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_idle;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_wr, w_ovr_set;
    logic [7:0] w_tx_byte;

    assign w_tx_full  = (r_tx_cnt == TX_FULL);
    assign w_tx_empty = (r_tx_cnt == (TX_AW+1)'(0));
    assign w_rx_full  = (r_rx_cnt == RX_FULL);
    assign w_rx_empty = (r_rx_cnt == (RX_AW+1)'(0));
    assign w_tx_idle  = w_tx_empty & (r_tx_state == S_IDLE);
    assign w_tx_byte  = r_tx_mem[r_tx_rp] & w_mask;

    // A full TX FIFO silently drops the write; the frame start is the only consumer.
    assign w_tx_push  = w_wr_tx & ~w_tx_full;
    assign w_tx_pop   = (r_tx_state == S_IDLE) & w_tx_en & ~w_tx_empty;
    // A push into a full RX FIFO only lands if the bus pops in the same cycle.
    assign w_rx_pop   = w_rd_rx & ~w_rx_empty;
    assign w_rx_wr    = w_rx_push & (~w_rx_full | w_rx_pop);
    assign w_ovr_set  = w_rx_push & w_rx_full & ~w_rx_pop;

    // ---------------- RX sampling events ----------------
    logic w_tx_tick, w_rx_tick, w_perr_set, w_ferr_set;
    assign w_tx_tick  = (r_tx_tmr >= (w_div - 16'd1));
    assign w_rx_tick  = (r_rx_tmr >= (w_div - 16'd1));
    assign w_rx_push  = w_rx_en & (r_rx_state == S_STOP) & w_rx_tick;
    assign w_perr_set = w_rx_push & w_par_en & (r_rx_par != par_calc(r_rx_shift, w_par_odd));
    assign w_ferr_set = w_rx_push & ~r_rx_s2;

    // ---------------- register read mux ----------------
    logic [31:0] w_status, w_rd_mux;
    assign w_status = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), w_tx_idle, r_frm_err, r_par_err,
                       r_overrun, w_rx_full, w_tx_empty, w_rx_empty, w_tx_full};

    // Select read data for the addressed register; popping DATA_RX when empty yields 0.
    always_comb begin
        w_rd_mux = 32'h0;
        case (bus.i_addr)
            8'h01:   w_rd_mux = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rp]};
            8'h02:   w_rd_mux = {9'h0, r_cfg};
            8'h03:   w_rd_mux = w_status;
            8'h04:   w_rd_mux = {29'h0, r_irq_en};
            default: w_rd_mux = 32'h0;
        endcase
    end

    assign bus.o_ack     = r_ack;
    assign bus.o_rd_data = r_rd_data;
    assign bus.o_busy    = 1'b0;
    assign o_uart_tx     = r_tx_line;
    assign o_irq         = (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty) |
                           (r_irq_en[2] & (r_overrun | r_par_err | r_frm_err));

    // Bus slave: registered ack/read data and byte-enabled CONFIG/IRQ_EN writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack     <= 1'b0;
            r_rd_data <= 32'h0;
            r_cfg     <= 23'h0;
            r_irq_en  <= 3'b000;
        end else begin
            r_ack     <= bus.i_rd_en | bus.i_wr_en;
            r_rd_data <= bus.i_rd_en ? w_rd_mux : 32'h0;
            if (w_wr_cfg && bus.i_be[0]) r_cfg[7:0]   <= bus.i_wr_data[7:0];
            if (w_wr_cfg && bus.i_be[1]) r_cfg[15:8]  <= bus.i_wr_data[15:8];
            if (w_wr_cfg && bus.i_be[2]) r_cfg[22:16] <= bus.i_wr_data[22:16];
            if (w_wr_irq)                r_irq_en     <= bus.i_wr_data[2:0];
        end
    end

    // Sticky error flags: a new error in the same cycle wins over write-1-to-clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_overrun <= w_ovr_set  | (r_overrun & ~(w_wr_stat & bus.i_wr_data[4]));
            r_par_err <= w_perr_set | (r_par_err & ~(w_wr_stat & bus.i_wr_data[5]));
            r_frm_err <= w_ferr_set | (r_frm_err & ~(w_wr_stat & bus.i_wr_data[6]));
        end
    end

    // TX FIFO storage (no reset needed; contents qualified by the count).
    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.i_wr_data[7:0];
    end

    // TX FIFO pointers and fill level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_wp  <= TX_AW'(0);
            r_tx_rp  <= TX_AW'(0);
            r_tx_cnt <= (TX_AW+1)'(0);
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PINC;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PINC;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + TX_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - TX_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // TX frame sequencer; the line level is registered so the start bit follows the pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_tmr   <= 16'h0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_line <= 1'b1;
                    r_tx_tmr  <= 16'h0;
                    r_tx_bit  <= 3'd0;
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_byte;
                        r_tx_par   <= par_calc(w_tx_byte, w_par_odd);
                        r_tx_line  <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_tick) begin
                        r_tx_tmr   <= 16'h0;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_tmr <= r_tx_tmr + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_tmr <= 16'h0;
                        if (r_tx_bit >= w_last) begin
                            r_tx_bit   <= 3'd0;
                            r_tx_line  <= w_par_en ? r_tx_par : 1'b1;
                            r_tx_state <= w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_line  <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_tmr <= r_tx_tmr + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_tx_tick) begin
                        r_tx_tmr   <= 16'h0;
                        r_tx_line  <= 1'b1;
                        r_tx_state <= S_STOP;
                    end else begin
                        r_tx_tmr <= r_tx_tmr + 16'd1;
                    end
                end
                S_STOP: begin
                    // r_tx_bit counts the first stop period when two stop bits are selected.
                    if (w_tx_tick) begin
                        r_tx_tmr <= 16'h0;
                        if (w_two_stop && (r_tx_bit == 3'd0)) begin
                            r_tx_bit <= 3'd1;
                        end else begin
                            r_tx_bit   <= 3'd0;
                            r_tx_state <= S_IDLE;
                        end
                    end else begin
                        r_tx_tmr <= r_tx_tmr + 16'd1;
                    end
                end
                default: begin
                    r_tx_state <= S_IDLE;
                    r_tx_line  <= 1'b1;
                end
            endcase
        end
    end

    // Two-stage synchroniser for the async RX pin plus a delayed copy for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= i_uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX frame sequencer: half-bit start recheck, then one sample per bit period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state <= S_IDLE;
            r_rx_tmr   <= 16'h0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_par   <= 1'b0;
        end else if (!w_rx_en) begin
            r_rx_state <= S_IDLE;
            r_rx_tmr   <= 16'h0;
            r_rx_bit   <= 3'd0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_tmr <= 16'h0;
                    r_rx_bit <= 3'd0;
                    if (!r_rx_s2 && r_rx_s3) begin
                        r_rx_shift <= 8'h00;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_tmr >= (w_half - 16'd1)) begin
                        r_rx_tmr   <= 16'h0;
                        r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_tmr <= r_rx_tmr + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_tmr             <= 16'h0;
                        r_rx_shift[r_rx_bit] <= r_rx_s2;
                        if (r_rx_bit >= w_last) begin
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_tmr <= r_rx_tmr + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_tmr   <= 16'h0;
                        r_rx_par   <= r_rx_s2;
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_tmr <= r_rx_tmr + 16'd1;
                    end
                end
                S_STOP: begin
                    // The byte is pushed by w_rx_push on this same sample edge.
                    if (w_rx_tick) begin
                        r_rx_tmr   <= 16'h0;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_tmr <= r_rx_tmr + 16'd1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // RX FIFO storage.
    always_ff @(posedge i_clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    // RX FIFO pointers and fill level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_wp  <= RX_AW'(0);
            r_rx_rp  <= RX_AW'(0);
            r_rx_cnt <= (RX_AW+1)'(0);
        end else begin
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + RX_PINC;
            if (w_rx_pop) r_rx_rp <= r_rx_rp + RX_PINC;
            case ({w_rx_wr, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + RX_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - RX_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_perif_uart_fifo.sv
// Directed bench for perif_uart_fifo (TX_DEPTH=4, RX_DEPTH=4).
module tb_perif_uart_fifo;
    logic clk = 1'b0;
    logic rst_n;
    logic tb_rx;
    logic loop;
    logic irq, uart_tx, uart_rx;
    int   n_checks = 0;
    int   n_fail   = 0;

    perif_uart_fifo_if bus();

    assign uart_rx = loop ? uart_tx : tb_rx;

    perif_uart_fifo #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_irq(irq), .i_uart_rx(uart_rx), .o_uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, output logic ack);
        @(negedge clk);
        bus.i_addr = a; bus.i_wr_data = d; bus.i_be = be; bus.i_wr_en = 1'b1;
        @(negedge clk);
        ack = bus.o_ack;
        bus.i_wr_en = 1'b0; bus.i_be = 4'h0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d, output logic ack);
        @(negedge clk);
        bus.i_addr = a; bus.i_rd_en = 1'b1;
        @(negedge clk);
        d = bus.o_rd_data; ack = bus.o_ack;
        bus.i_rd_en = 1'b0;
    endtask

    // Drive one serial frame on tb_rx; pmode 0 none, 1 even, 2 odd.
    task automatic send_frame(input logic [7:0] d, input int nb, input int pmode,
                              input logic pflip, input logic stop_v, input int n);
        logic p;
        p = 1'b0;
        @(negedge clk); tb_rx = 1'b0; repeat (n) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            tb_rx = d[i]; p = p ^ d[i]; repeat (n) @(negedge clk);
        end
        if (pmode != 0) begin
            tb_rx = p ^ (pmode == 2) ^ pflip; repeat (n) @(negedge clk);
        end
        tb_rx = stop_v; repeat (n) @(negedge clk);
        tb_rx = 1'b1; repeat (2*n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic a;
        repeat (3) @(negedge clk);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx got=%b exp=1", uart_tx); end
        n_checks++; if (bus.o_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data got=%h exp=0", bus.o_rd_data); end
        n_checks++; if (bus.o_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", bus.o_ack); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
        n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
        rst_n = 1'b1;
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL rst_status got=%h exp=00000086", d); end
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rst_rd_ack got=%b exp=1", a); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d; logic a;
        bus_wr(8'h02, 32'h0061_0010, 4'hF, a);
        bus_wr(8'h00, 32'h0000_0000, 4'h1, a);
        repeat (1 + 8 + 32) @(negedge clk);
        n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_before got=%b exp=0", uart_tx); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got=%b exp=1", uart_tx); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL midrst_status got=%h exp=00000086", d); end
        bus_rd(8'h02, d, a);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_cfg got=%h exp=0", d); end
    endtask

    task automatic test_tx_8n1();
        logic [31:0] d; logic a; logic [9:0] exp_line;
        exp_line = {1'b1, 8'hA5, 1'b0};
        bus_wr(8'h02, 32'h0061_0010, 4'hF, a);
        bus_wr(8'h00, 32'h0000_00A5, 4'h1, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL tx_wr_ack got=%b exp=1", a); end
        @(negedge clk);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (16) @(negedge clk);
            n_checks++;
            if (uart_tx !== exp_line[k]) begin n_fail++; $display("FAIL tx_bit%0d got=%b exp=%b", k, uart_tx, exp_line[k]); end
        end
        repeat (9) @(negedge clk);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL tx_idle_status got=%h exp=00000086", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d; logic a;
        loop = 1'b1;
        bus_wr(8'h02, 32'h0057_000A, 4'hF, a);
        bus_wr(8'h00, 32'h0000_0041, 4'h1, a);
        bus_wr(8'h00, 32'h0000_007F, 4'h1, a);
        repeat (150) @(negedge clk);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0104) begin n_fail++; $display("FAIL lb_status_l1 got=%h exp=00000104", d); end
        repeat (120) @(negedge clk);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0284) begin n_fail++; $display("FAIL lb_status_l2 got=%h exp=00000284", d); end
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0000_0041) begin n_fail++; $display("FAIL lb_byte0 got=%h exp=00000041", d); end
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0184) begin n_fail++; $display("FAIL lb_status_l1b got=%h exp=00000184", d); end
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_byte1 got=%h exp=0000007f", d); end
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL lb_status_l0 got=%h exp=00000086", d); end
        bus_wr(8'h02, 32'h0, 4'hF, a);
        loop = 1'b0;
    endtask

    task automatic test_overrun();
        logic [31:0] d; logic a; logic [7:0] exp_b;
        bus_wr(8'h02, 32'h0062_0010, 4'hF, a);
        send_frame(8'h11, 8, 0, 1'b0, 1'b1, 16);
        send_frame(8'h22, 8, 0, 1'b0, 1'b1, 16);
        send_frame(8'h33, 8, 0, 1'b0, 1'b1, 16);
        send_frame(8'h44, 8, 0, 1'b0, 1'b1, 16);
        send_frame(8'h55, 8, 0, 1'b0, 1'b1, 16);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_049C) begin n_fail++; $display("FAIL ovr_status got=%h exp=0000049c", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_irq_masked got=%b exp=0", irq); end
        bus_wr(8'h03, 32'h0000_0010, 4'h1, a);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_048C) begin n_fail++; $display("FAIL ovr_clear got=%h exp=0000048c", d); end
        for (int k = 0; k < 4; k++) begin
            exp_b = 8'h11 * 8'(k + 1);
            bus_rd(8'h01, d, a);
            n_checks++;
            if (d !== {24'h0, exp_b}) begin n_fail++; $display("FAIL ovr_byte%0d got=%h exp=%h", k, d, exp_b); end
        end
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_read got=%h exp=0", d); end
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL empty_read_ack got=%b exp=1", a); end
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL ovr_drained got=%h exp=00000086", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic a;
        bus_wr(8'h02, 32'h0066_0010, 4'hF, a);
        bus_wr(8'h04, 32'h0, 4'h1, a);
        send_frame(8'h5A, 8, 1, 1'b1, 1'b1, 16);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_01A4) begin n_fail++; $display("FAIL perr_status got=%h exp=000001a4", d); end
        send_frame(8'h3C, 8, 1, 1'b0, 1'b0, 16);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_02E4) begin n_fail++; $display("FAIL ferr_status got=%h exp=000002e4", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL err_irq_off got=%b exp=0", irq); end
        bus_wr(8'h04, 32'h4, 4'h1, a);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL err_irq_on got=%b exp=1", irq); end
        bus_wr(8'h03, 32'h60, 4'h1, a);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL err_irq_clr got=%b exp=0", irq); end
        bus_wr(8'h04, 32'h1, 4'h1, a);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rx_irq got=%b exp=1", irq); end
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0000_005A) begin n_fail++; $display("FAIL perr_byte got=%h exp=0000005a", d); end
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0000_003C) begin n_fail++; $display("FAIL ferr_byte got=%h exp=0000003c", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rx_irq_empty got=%b exp=0", irq); end
        bus_wr(8'h04, 32'h2, 4'h1, a);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tx_irq got=%b exp=1", irq); end
        bus_wr(8'h04, 32'h0, 4'h1, a);
    endtask

    task automatic test_glitch();
        logic [31:0] d; logic a;
        bus_wr(8'h02, 32'h0062_0010, 4'hF, a);
        bus_wr(8'h02, 32'hFFFF_FFFF, 4'h1, a);
        bus_rd(8'h02, d, a);
        n_checks++; if (d !== 32'h0062_00FF) begin n_fail++; $display("FAIL cfg_be got=%h exp=006200ff", d); end
        bus_wr(8'h02, 32'h0062_0010, 4'hF, a);
        @(negedge clk); tb_rx = 1'b0;
        @(negedge clk); tb_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL glitch_status got=%h exp=00000086", d); end
        send_frame(8'h96, 8, 0, 1'b0, 1'b1, 16);
        bus_rd(8'h01, d, a);
        n_checks++; if (d !== 32'h0000_0096) begin n_fail++; $display("FAIL glitch_after got=%h exp=00000096", d); end
        bus_wr(8'h02, 32'h0, 4'hF, a);
    endtask

    task automatic test_tx_full();
        logic [31:0] d; logic a;
        bus_wr(8'h02, 32'h0000_0010, 4'hF, a);
        for (int k = 0; k < 5; k++) begin
            bus_wr(8'h00, 32'(8'h30 + 8'(k)), 4'h1, a);
            n_checks++;
            if (a !== 1'b1) begin n_fail++; $display("FAIL txfull_ack%0d got=%b exp=1", k, a); end
        end
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0004_0003) begin n_fail++; $display("FAIL txfull_status got=%h exp=00040003", d); end
        bus_wr(8'h10, 32'hFFFF_FFFF, 4'hF, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_ack got=%b exp=1", a); end
        bus_rd(8'h10, d, a);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got=%h exp=0", d); end
        bus_rd(8'h00, d, a);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL datatx_rd got=%h exp=0", d); end
        bus_wr(8'h02, 32'h0061_0002, 4'hF, a);
        repeat (120) @(negedge clk);
        bus_rd(8'h03, d, a);
        n_checks++; if (d !== 32'h0000_0086) begin n_fail++; $display("FAIL txfull_drain got=%h exp=00000086", d); end
    endtask

    initial begin
        rst_n = 1'b0;
        tb_rx = 1'b1;
        loop  = 1'b0;
        bus.i_addr = 8'h00; bus.i_be = 4'h0; bus.i_wr_en = 1'b0;
        bus.i_wr_data = 32'h0; bus.i_rd_en = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_tx_8n1();
        test_loopback();
        test_overrun();
        test_errors();
        test_glitch();
        test_tx_full();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
